// File: rtl/hrange_pkg.sv
// Shared types and helpers for the lane-parallel range generator.
// Range tests run in an extended signed width so lane values never wrap.
package hrange_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Widest extended value the range helper accepts; callers sign-extend into it.
    localparam int MAX_EXT_WIDTH = 128;

    // WIDTH + log2(LANES) + 2 bits hold lane0 + k*step and lane0 + LANES*step exactly.
    function automatic int ext_width(input int width, input int lanes);
        return width + $clog2(lanes) + 2;
    endfunction

    function automatic logic lane_in_range(
        input logic signed [MAX_EXT_WIDTH-1:0] value_ext,
        input logic signed [MAX_EXT_WIDTH-1:0] limit,
        input logic                            step_sign
    );
        return step_sign ? (value_ext > limit) : (value_ext < limit);
    endfunction

endpackage

// File: rtl/hrange_lane_calc.sv
// Combinational lane expansion: values lane0 + k*step for every lane, their
// in-range mask, and the first value of the following beat.
module hrange_lane_calc
    import hrange_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LANES = 1
) (
    input  logic [WIDTH-1:0]       lane0,
    input  logic [WIDTH-1:0]       step,
    input  logic [WIDTH-1:0]       limit,
    output logic [LANES*WIDTH-1:0] lanes,
    output logic [LANES-1:0]       mask,
    output logic [WIDTH-1:0]       next_lane0,
    output logic                   next_in_range
);

    localparam int EXT = ext_width(WIDTH, LANES);

    logic signed [EXT-1:0] lane0_ext;
    logic signed [EXT-1:0] step_ext;
    logic signed [EXT-1:0] limit_ext;
    logic signed [EXT-1:0] next_ext;

    assign lane0_ext = EXT'(signed'(lane0));
    assign step_ext  = EXT'(signed'(step));
    assign limit_ext = EXT'(signed'(limit));

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [EXT-1:0] value_ext;
            assign value_ext = lane0_ext + step_ext * EXT'(gi);
            // Out-of-range lanes still carry the truncated value so the bus is deterministic.
            assign lanes[gi*WIDTH +: WIDTH] = value_ext[WIDTH-1:0];
            assign mask[gi] = lane_in_range(MAX_EXT_WIDTH'(value_ext),
                                            MAX_EXT_WIDTH'(limit_ext),
                                            step[WIDTH-1]);
        end
    endgenerate

    assign next_ext      = lane0_ext + step_ext * EXT'(LANES);
    assign next_lane0    = next_ext[WIDTH-1:0];
    assign next_in_range = lane_in_range(MAX_EXT_WIDTH'(next_ext),
                                         MAX_EXT_WIDTH'(limit_ext),
                                         step[WIDTH-1]);

endmodule

// File: rtl/hrange_lanes.sv
// Lane-parallel Python range(base, limit, step) generator with start/ready/valid/done
// handshake. Optional _abort input is enabled by defining HRANGE_LANES_ABORT_EN.
module hrange_lanes
    import hrange_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int IDX_WIDTH = 32,
    parameter int LANES     = 1
) (
    input  logic                   _clock,
    input  logic                   _reset,
    input  logic                   _start,
    input  logic                   _ready,
`ifdef HRANGE_LANES_ABORT_EN
    input  logic                   _abort,
`endif
    input  logic [WIDTH-1:0]       base,
    input  logic [WIDTH-1:0]       limit,
    input  logic [WIDTH-1:0]       step,
    output logic                   _done,
    output logic                   _valid,
    output logic                   _error,
    output logic [IDX_WIDTH-1:0]   _0,
    output logic [LANES*WIDTH-1:0] _1,
    output logic [LANES-1:0]       _mask
);

    state_t                 state_reg,  state_next;
    logic [WIDTH-1:0]       step_reg,   step_next;
    logic [WIDTH-1:0]       limit_reg,  limit_next;
    logic [WIDTH-1:0]       nxt_reg,    nxt_next;
    logic                   nxt_ok_reg, nxt_ok_next;
    logic [IDX_WIDTH-1:0]   idx_reg,    idx_next;
    logic [LANES*WIDTH-1:0] lanes_reg,  lanes_next;
    logic [LANES-1:0]       mask_reg,   mask_next;
    logic                   error_reg,  error_next;

    logic [WIDTH-1:0]       calc_lane0;
    logic [WIDTH-1:0]       calc_step;
    logic [WIDTH-1:0]       calc_limit;
    logic [LANES*WIDTH-1:0] calc_lanes;
    logic [LANES-1:0]       calc_mask;
    logic [WIDTH-1:0]       calc_next;
    logic                   calc_next_ok;
    logic                   abort_req;

`ifdef HRANGE_LANES_ABORT_EN
    assign abort_req = _abort;
`else
    assign abort_req = 1'b0;
`endif

    // The calculator always looks one beat ahead: while idle it expands the
    // requested base, while running it expands the beat that follows the visible one.
    assign calc_lane0 = (state_reg == IDLE) ? base  : nxt_reg;
    assign calc_step  = (state_reg == IDLE) ? step  : step_reg;
    assign calc_limit = (state_reg == IDLE) ? limit : limit_reg;

    hrange_lane_calc #(
        .WIDTH(WIDTH),
        .LANES(LANES)
    ) u_calc (
        .lane0        (calc_lane0),
        .step         (calc_step),
        .limit        (calc_limit),
        .lanes        (calc_lanes),
        .mask         (calc_mask),
        .next_lane0   (calc_next),
        .next_in_range(calc_next_ok)
    );

    always_comb begin
        state_next  = state_reg;
        step_next   = step_reg;
        limit_next  = limit_reg;
        nxt_next    = nxt_reg;
        nxt_ok_next = nxt_ok_reg;
        idx_next    = idx_reg;
        lanes_next  = lanes_reg;
        mask_next   = mask_reg;
        error_next  = error_reg;
        case (state_reg)
            IDLE: begin
                if (_start) begin
                    error_next = (step == '0);
                    if (step != '0 && calc_mask[0]) begin
                        state_next  = RUN;
                        step_next   = step;
                        limit_next  = limit;
                        nxt_next    = calc_next;
                        nxt_ok_next = calc_next_ok;
                        idx_next    = '0;
                        lanes_next  = calc_lanes;
                        mask_next   = calc_mask;
                    end
                end
            end
            RUN: begin
                if (abort_req) begin
                    state_next = IDLE;
                    mask_next  = '0;
                end else if (_ready) begin
                    idx_next = idx_reg + IDX_WIDTH'(LANES);
                    if (nxt_ok_reg) begin
                        nxt_next    = calc_next;
                        nxt_ok_next = calc_next_ok;
                        lanes_next  = calc_lanes;
                        mask_next   = calc_mask;
                    end else begin
                        state_next = IDLE;
                        mask_next  = '0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge _clock or posedge _reset) begin
        if (_reset) begin
            state_reg  <= IDLE;
            step_reg   <= '0;
            limit_reg  <= '0;
            nxt_reg    <= '0;
            nxt_ok_reg <= 1'b0;
            idx_reg    <= '0;
            lanes_reg  <= '0;
            mask_reg   <= '0;
            error_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            step_reg   <= step_next;
            limit_reg  <= limit_next;
            nxt_reg    <= nxt_next;
            nxt_ok_reg <= nxt_ok_next;
            idx_reg    <= idx_next;
            lanes_reg  <= lanes_next;
            mask_reg   <= mask_next;
            error_reg  <= error_next;
        end
    end

    assign _done  = (state_reg == IDLE);
    assign _valid = (state_reg == RUN);
    assign _error = error_reg;
    assign _0     = idx_reg;
    assign _1     = lanes_reg;
    assign _mask  = mask_reg;

endmodule

// File: tb/tb_hrange_lanes.sv
// Directed scoreboard bench for hrange_lanes: three instances cover LANES=1,
// LANES=4 and a narrow WIDTH=8/LANES=2 configuration.
module tb_hrange_lanes;

    typedef struct {
        logic [31:0]  idx;
        logic [127:0] lanes;
        logic [7:0]   mask;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int          sel = 0;
    logic        d_start = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] base = '0, limit = '0, step = '0;
`ifdef HRANGE_LANES_ABORT_EN
    logic        abort = 1'b0;
`endif

    logic        start_a, start_b, start_c;
    assign start_a = d_start && (sel == 0);
    assign start_b = d_start && (sel == 1);
    assign start_c = d_start && (sel == 2);

    logic        done_a, valid_a, error_a;
    logic [31:0] idx_a;
    logic [31:0] lanes_a;
    logic [0:0]  mask_a;
    logic        done_b, valid_b, error_b;
    logic [31:0] idx_b;
    logic [127:0] lanes_b;
    logic [3:0]  mask_b;
    logic        done_c, valid_c, error_c;
    logic [7:0]  idx_c;
    logic [15:0] lanes_c;
    logic [1:0]  mask_c;

    hrange_lanes #(.WIDTH(32), .IDX_WIDTH(32), .LANES(1)) dut_a (
        ._clock(clk), ._reset(rst), ._start(start_a), ._ready(ready),
`ifdef HRANGE_LANES_ABORT_EN
        ._abort(abort),
`endif
        .base(base), .limit(limit), .step(step),
        ._done(done_a), ._valid(valid_a), ._error(error_a),
        ._0(idx_a), ._1(lanes_a), ._mask(mask_a)
    );

    hrange_lanes #(.WIDTH(32), .IDX_WIDTH(32), .LANES(4)) dut_b (
        ._clock(clk), ._reset(rst), ._start(start_b), ._ready(ready),
`ifdef HRANGE_LANES_ABORT_EN
        ._abort(1'b0),
`endif
        .base(base), .limit(limit), .step(step),
        ._done(done_b), ._valid(valid_b), ._error(error_b),
        ._0(idx_b), ._1(lanes_b), ._mask(mask_b)
    );

    hrange_lanes #(.WIDTH(8), .IDX_WIDTH(8), .LANES(2)) dut_c (
        ._clock(clk), ._reset(rst), ._start(start_c), ._ready(ready),
`ifdef HRANGE_LANES_ABORT_EN
        ._abort(1'b0),
`endif
        .base(base[7:0]), .limit(limit[7:0]), .step(step[7:0]),
        ._done(done_c), ._valid(valid_c), ._error(error_c),
        ._0(idx_c), ._1(lanes_c), ._mask(mask_c)
    );

    logic         v_valid, v_done, v_error;
    logic [31:0]  v_idx;
    logic [127:0] v_lanes;
    logic [7:0]   v_mask;

    always_comb begin
        v_valid = 1'b0; v_done = 1'b0; v_error = 1'b0;
        v_idx = '0; v_lanes = '0; v_mask = '0;
        case (sel)
            0: begin
                v_valid = valid_a; v_done = done_a; v_error = error_a;
                v_idx = idx_a; v_lanes = 128'(lanes_a); v_mask = 8'(mask_a);
            end
            1: begin
                v_valid = valid_b; v_done = done_b; v_error = error_b;
                v_idx = idx_b; v_lanes = lanes_b; v_mask = 8'(mask_b);
            end
            default: begin
                v_valid = valid_c; v_done = done_c; v_error = error_c;
                v_idx = 32'(idx_c); v_lanes = 128'(lanes_c); v_mask = 8'(mask_c);
            end
        endcase
    end

    int    total = 0;
    int    bad = 0;
    beat_t q[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Builds the expected beats from Python range semantics, starts the run and
    // consumes beats, optionally toggling ready 1,0,1,0...
    task automatic run_seq(input int s_sel, input longint b, input longint l, input longint s,
                           input bit toggle, input string tag);
        int           w, ln, n, beats;
        longint       v, ev;
        logic [127:0] t, wmask, prev_lanes;
        logic [31:0]  prev_idx;
        logic [7:0]   prev_mask;
        beat_t        e;
        bit           held, rd;
        w  = (s_sel == 2) ? 8 : 32;
        ln = (s_sel == 0) ? 1 : ((s_sel == 1) ? 4 : 2);
        wmask = (128'd1 << w) - 128'd1;
        n = 0;
        v = b;
        while (s != 0 && ((s > 0 && v < l) || (s < 0 && v > l)) && n < 1000) begin
            n++;
            v += s;
        end
        beats = (n + ln - 1) / ln;
        for (int bi = 0; bi < beats; bi++) begin
            e.idx = 32'(bi * ln);
            e.lanes = '0;
            e.mask = '0;
            for (int k = 0; k < ln; k++) begin
                ev = b + longint'(bi * ln + k) * s;
                t = 128'(ev) & wmask;
                e.lanes = e.lanes | (t << (k * w));
                if (bi * ln + k < n) e.mask[k] = 1'b1;
            end
            q.push_back(e);
        end
        sel = s_sel;
        base = 32'(b); limit = 32'(l); step = 32'(s);
        d_start = 1'b1;
        ready = 1'b0;
        @(negedge clk);
        d_start = 1'b0;
        held = 1'b0;
        prev_idx = '0; prev_lanes = '0; prev_mask = '0;
        for (int cyc = 0; cyc < 100 && q.size() > 0; cyc++) begin
            if (held) begin
                check({tag, "_hold_idx"}, 128'(v_idx), 128'(prev_idx));
                check({tag, "_hold_lanes"}, v_lanes, prev_lanes);
                check({tag, "_hold_mask"}, 128'(v_mask), 128'(prev_mask));
                held = 1'b0;
            end
            if (!v_valid) begin
                check({tag, "_valid"}, 128'(v_valid), 128'(1));
                break;
            end
            rd = toggle ? (cyc % 2 == 0) : 1'b1;
            ready = rd;
            if (rd) begin
                e = q.pop_front();
                check({tag, "_idx"}, 128'(v_idx), 128'(e.idx));
                check({tag, "_lanes"}, v_lanes, e.lanes);
                check({tag, "_mask"}, 128'(v_mask), 128'(e.mask));
                $display("beat %s idx=%0d lanes=%0h mask=%b", tag, v_idx, v_lanes, v_mask);
            end else begin
                prev_idx = v_idx; prev_lanes = v_lanes; prev_mask = v_mask;
                held = 1'b1;
            end
            @(negedge clk);
        end
        ready = 1'b0;
        check({tag, "_left"}, 128'(q.size()), 128'(0));
        check({tag, "_end_done"}, 128'(v_done), 128'(1));
        check({tag, "_end_valid"}, 128'(v_valid), 128'(0));
        q.delete();
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_done", 128'(done_a), 128'(1));
        check("rst_valid", 128'(valid_a), 128'(0));
        check("rst_error", 128'(error_a), 128'(0));
        check("rst_idx", 128'(idx_a), 128'(0));
        check("rst_lanes_b", lanes_b, 128'(0));
        check("rst_mask_b", 128'(mask_b), 128'(0));
        rst = 1'b0;
        @(negedge clk);

        // LANES=1, three back-to-back identical runs
        run_seq(0, 0, 10, 2, 1'b0, "l1_r1");
        run_seq(0, 0, 10, 2, 1'b0, "l1_r2");
        run_seq(0, 0, 10, 2, 1'b0, "l1_r3");

        // LANES=4 with partial final beat, free-running and under backpressure
        run_seq(1, 0, 10, 2, 1'b0, "l4");
        run_seq(1, 0, 10, 2, 1'b1, "l4_bp");
        run_seq(0, 0, 10, 2, 1'b1, "l1_bp");

        // LANES=2, WIDTH=8: negative step and no-wrap boundary
        run_seq(2, 5, -2, -3, 1'b0, "neg");
        run_seq(2, 120, 127, 5, 1'b0, "edge");
        run_seq(2, -100, -128, -9, 1'b1, "neg_edge");

        // Zero step flags an error; an empty range clears it without a beat
        run_seq(2, 3, 9, 0, 1'b0, "zero");
        check("zero_error", 128'(v_error), 128'(1));
        run_seq(2, 3, 3, 1, 1'b0, "empty");
        check("empty_error", 128'(v_error), 128'(0));

        // Asynchronous reset in the middle of a run
        sel = 0; base = 0; limit = 100; step = 1;
        d_start = 1'b1;
        @(negedge clk);
        d_start = 1'b0;
        check("mid_valid_before", 128'(valid_a), 128'(1));
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", 128'(valid_a), 128'(0));
        check("mid_rst_done", 128'(done_a), 128'(1));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_seq(0, 0, 10, 2, 1'b0, "after_rst");

`ifdef HRANGE_LANES_ABORT_EN
        sel = 0; base = 0; limit = 100; step = 1;
        d_start = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        d_start = 1'b0;
        check("abort_b0_idx", 128'(idx_a), 128'(0));
        check("abort_b0_valid", 128'(valid_a), 128'(1));
        @(negedge clk);
        check("abort_b1_idx", 128'(idx_a), 128'(1));
        check("abort_b1_lane", 128'(lanes_a), 128'(1));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        ready = 1'b0;
        check("abort_valid", 128'(valid_a), 128'(0));
        check("abort_done", 128'(done_a), 128'(1));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
